// File: rtl/mhe_pkg.sv
// Shared types and helpers for the multi-hit encoder: burst state encoding and
// a population-count function usable by any request-vector width up to MHE_MAX_N.
package mhe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    NONE = 2'd2
  } mhe_state_e;

  localparam int MHE_MAX_N = 256;

  // Callers zero-extend narrower vectors and truncate the result to their own W+1.
  function automatic logic [8:0] popcount(input logic [MHE_MAX_N-1:0] vec);
    logic [8:0] cnt;
    cnt = 9'd0;
    for (int i = 0; i < MHE_MAX_N; i++) begin
      cnt = cnt + {8'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/multi_hit_encoder_prio_enc.sv
// Combinational N-to-W priority encoder with selectable direction, plus a flag
// that is high when exactly one request bit is set.
module prio_enc #(
  parameter  int N         = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int W         = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         onehot_single_o
);

  localparam logic [N-1:0] ONE_VEC = {{(N-1){1'b0}}, 1'b1};

  // Scan so that the winning bit is the last one written.
  always_comb begin
    idx_o = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (vec_i[i]) begin
          idx_o = i[W-1:0];
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec_i[i]) begin
          idx_o = i[W-1:0];
        end
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  always_comb begin
    onehot_single_o = (vec_i != '0) && ((vec_i & (vec_i - ONE_VEC)) == '0);
  end

endmodule

// File: rtl/multi_hit_encoder.sv
// Captures an N-bit request vector and emits the index of every set bit, one per
// accepted output beat, with last/none flags and the vector's hit count.
module multi_hit_encoder
  import mhe_pkg::*;
#(
  parameter  int N         = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int W         = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none,
  output logic [W:0]   out_count
);

  localparam logic [N-1:0] ONE_VEC = {{(N-1){1'b0}}, 1'b1};

  mhe_state_e   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W:0]   count_q, count_d;
  logic [W-1:0] enc_idx_s;
  logic         enc_single_s;

  prio_enc #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio_enc (
    .vec_i           (pending_q),
    .idx_o           (enc_idx_s),
    .onehot_single_o (enc_single_s)
  );

  // State, pending-vector and hit-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // Capture in IDLE, retire one bit per accepted beat in EMIT.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_vec;
          count_d   = (W+1)'(popcount(MHE_MAX_N'(in_vec)));
          state_d   = (in_vec != '0) ? EMIT : NONE;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & ~(ONE_VEC << enc_idx_s);
          state_d   = enc_single_s ? IDLE : EMIT;
        end else begin
          state_d = EMIT;
        end
      end
      NONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = NONE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
        count_d   = '0;
      end
    endcase
  end

  // Output decode depends only on registered state, never on out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    out_count = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_idx   = enc_idx_s;
        out_last  = enc_single_s;
        out_count = count_q;
      end
      NONE: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_none  = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multi_hit_encoder.sv
// Randomised self-checking bench for multi_hit_encoder: three instances
// (N=8 MSB-first, N=8 LSB-first, N=5 LSB-first) checked against a list model.
module tb_multi_hit_encoder;

  logic clk;
  logic rst_n;

  logic [2:0]      in_valid_s;
  logic [2:0]      in_ready_s;
  logic [2:0][7:0] in_vec_s;
  logic [2:0]      out_valid_s;
  logic [2:0]      out_ready_s;
  logic [2:0][2:0] out_idx_s;
  logic [2:0]      out_last_s;
  logic [2:0]      out_none_s;
  logic [2:0][3:0] out_count_s;

  int checks_r;
  int failures_r;

  multi_hit_encoder #(.N(8), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_vec(in_vec_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_idx(out_idx_s[0]),
    .out_last(out_last_s[0]), .out_none(out_none_s[0]), .out_count(out_count_s[0])
  );

  multi_hit_encoder #(.N(8), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_vec(in_vec_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_idx(out_idx_s[1]),
    .out_last(out_last_s[1]), .out_none(out_none_s[1]), .out_count(out_count_s[1])
  );

  multi_hit_encoder #(.N(5), .MSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]), .in_vec(in_vec_s[2][4:0]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .out_idx(out_idx_s[2]),
    .out_last(out_last_s[2]), .out_none(out_none_s[2]), .out_count(out_count_s[2])
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      failures_r++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Offer one vector to instance d and follow its burst to completion.
  // First beat is stalled for exactly hold cycles; later beats stall randomly.
  task automatic run_vec(input int d, input logic [7:0] vec, input int hold, input int stall_pct);
    int q[$];
    int n;
    int guard;
    bit msb;
    n   = (d == 2) ? 5 : 8;
    msb = (d == 0);
    for (int i = 0; i < n; i++) begin
      if (vec[i]) q.push_back(i);
    end
    if (msb) q.reverse();

    check_eq($sformatf("d%0d_idle_ready", d), 32'(in_ready_s[d]), 32'd1);
    in_valid_s[d] = 1'b1;
    in_vec_s[d]   = vec;
    @(posedge clk); #1;
    in_valid_s[d] = 1'b0;
    in_vec_s[d]   = 8'($urandom);

    if (q.size() == 0) begin
      guard = 0;
      do begin
        out_ready_s[d] = (guard >= hold);
        check_eq($sformatf("d%0d_none_valid", d), 32'(out_valid_s[d]), 32'd1);
        check_eq($sformatf("d%0d_none_flag", d), 32'(out_none_s[d]), 32'd1);
        check_eq($sformatf("d%0d_none_last", d), 32'(out_last_s[d]), 32'd1);
        check_eq($sformatf("d%0d_none_idx", d), 32'(out_idx_s[d]), 32'd0);
        check_eq($sformatf("d%0d_none_count", d), 32'(out_count_s[d]), 32'd0);
        check_eq($sformatf("d%0d_none_inrdy", d), 32'(in_ready_s[d]), 32'd0);
        guard++;
        @(posedge clk); #1;
      end while (!out_ready_s[d]);
    end else begin
      for (int k = 0; k < q.size(); k++) begin
        guard = 0;
        do begin
          if (k == 0) out_ready_s[d] = (guard >= hold);
          else        out_ready_s[d] = (int'($urandom_range(99)) >= stall_pct) || (guard >= 4);
          check_eq($sformatf("d%0d_valid_b%0d", d, k), 32'(out_valid_s[d]), 32'd1);
          check_eq($sformatf("d%0d_idx_b%0d", d, k), 32'(out_idx_s[d]), 32'(q[k]));
          check_eq($sformatf("d%0d_last_b%0d", d, k), 32'(out_last_s[d]), 32'(k == q.size() - 1));
          check_eq($sformatf("d%0d_none_b%0d", d, k), 32'(out_none_s[d]), 32'd0);
          check_eq($sformatf("d%0d_count_b%0d", d, k), 32'(out_count_s[d]), 32'(q.size()));
          check_eq($sformatf("d%0d_inrdy_b%0d", d, k), 32'(in_ready_s[d]), 32'd0);
          guard++;
          @(posedge clk); #1;
        end while (!out_ready_s[d]);
      end
    end
    out_ready_s[d] = 1'b0;
    check_eq($sformatf("d%0d_ready_after", d), 32'(in_ready_s[d]), 32'd1);
    check_eq($sformatf("d%0d_valid_after", d), 32'(out_valid_s[d]), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("%s_inrdy_d%0d", tag, d), 32'(in_ready_s[d]), 32'd1);
      check_eq($sformatf("%s_valid_d%0d", tag, d), 32'(out_valid_s[d]), 32'd0);
      check_eq($sformatf("%s_idx_d%0d", tag, d), 32'(out_idx_s[d]), 32'd0);
      check_eq($sformatf("%s_last_d%0d", tag, d), 32'(out_last_s[d]), 32'd0);
      check_eq($sformatf("%s_none_d%0d", tag, d), 32'(out_none_s[d]), 32'd0);
      check_eq($sformatf("%s_count_d%0d", tag, d), 32'(out_count_s[d]), 32'd0);
    end
  endtask

  // Directed scenarios followed by randomised bursts on every instance.
  initial begin
    logic [7:0] v;
    checks_r    = 0;
    failures_r  = 0;
    rst_n       = 1'b0;
    in_valid_s  = '0;
    in_vec_s    = '0;
    out_ready_s = '0;
    #12;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec(0, 8'b1010_0100, 0, 0);
    run_vec(0, 8'h00, 0, 0);
    run_vec(0, 8'b1100_0000, 3, 0);
    for (int b = 0; b < 8; b++) begin
      v = 8'd1 << b;
      run_vec(0, v, 0, 0);
    end
    run_vec(1, 8'b1000_0001, 0, 0);
    run_vec(2, 8'b0001_1111, 0, 0);
    run_vec(0, 8'hFF, 1, 20);

    // Reset during a full-vector burst, after the first beat is accepted.
    in_valid_s[0] = 1'b1;
    in_vec_s[0]   = 8'hFF;
    @(posedge clk); #1;
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b1;
    check_eq("mid_first_idx", 32'(out_idx_s[0]), 32'd7);
    @(posedge clk); #1;
    check_eq("mid_second_idx", 32'(out_idx_s[0]), 32'd6);
    rst_n = 1'b0;
    #1;
    check_eq("mid_async_valid", 32'(out_valid_s[0]), 32'd0);
    out_ready_s[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state("post_rst");
    run_vec(0, 8'h10, 0, 0);

    for (int r = 0; r < 40; r++) begin
      for (int d = 0; d < 3; d++) begin
        v = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom);
        run_vec(d, v, int'($urandom_range(2)), 30);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
